rom_read_sequencer: RTL and testbench
=====================================

Name: rom_read_sequencer

Overview:
- Drives the parallel ROM chip. Walks every address 0..2^ADDRESS_WIDTH-1 and applies chip-enable/output-enable timing.
- Captures each data byte and hands it downstream (serial transmitter) over a valid/ready handshake.
- Its current address feeds address_display.address_line, directly upstream of the seven-segment display.

Parameters:
- ADDRESS_WIDTH, 9, ROM address bus width; last address = 2^ADDRESS_WIDTH-1.
- DATA_WIDTH, 8, ROM data bus width.
- SETUP_CYCLES, 2, clocks the address is held with ce_n low and oe_n high before output enable (>=1).
- ACCESS_CYCLES, 50, clocks oe_n is held low before data capture (>=1; 50 = 1 us at 50 MHz).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  single-cycle request to begin a full dump; sampled in IDLE and DONE only.
- abort  in  1  stops the dump and returns to IDLE.
- rom_data  in  DATA_WIDTH  ROM data bus.
- rom_address  out  ADDRESS_WIDTH  ROM address bus; also drives address_display.address_line.
- rom_ce_n  out  1  ROM chip enable, active-low.
- rom_oe_n  out  1  ROM output enable, active-low.
- data_out  out  DATA_WIDTH  captured byte.
- data_valid  out  1  data_out holds an untransferred byte.
- data_ready  in  1  downstream accepts a byte.
- busy  out  1  dump in progress (any state except IDLE and DONE).
- done  out  1  full dump completed; held high until the next start or reset.

Behaviour:
- All outputs are registered. All state changes occur on posedge clk.
- Reset (reset==0) overrides everything, including mid-dump, at the next edge:
  - state IDLE; rom_address 0; rom_ce_n 1; rom_oe_n 1;
  - data_out 0; data_valid 0; busy 0; done 0; wait counter 0.
- States: IDLE, SETUP, ACCESS, HANDOFF, DONE.
- IDLE:
  - ce_n=1, oe_n=1.
  - start=1 -> SETUP with rom_address=0, ce_n=0, busy=1, wait counter cleared.
- SETUP:
  - ce_n=0, oe_n=1, address stable.
  - After SETUP_CYCLES clocks in SETUP -> ACCESS, with oe_n=0 from the first ACCESS cycle.
- ACCESS:
  - ce_n=0, oe_n=0.
  - On the edge ending the ACCESS_CYCLES-th cycle:
    - data_out <= rom_data; data_valid <= 1;
    - oe_n <= 1; ce_n <= 1; go to HANDOFF.
- HANDOFF:
  - data_valid=1; data_out and rom_address held stable.
  - A transfer occurs on an edge where data_valid && data_ready. On transfer, data_valid <= 0 and:
    - if rom_address == 2^ADDRESS_WIDTH-1: go to DONE, done <= 1, busy <= 0; rom_address holds the last address, with no wrap.
    - otherwise: rom_address <= rom_address+1, ce_n <= 0, go to SETUP.
  - While data_ready is low, the state holds indefinitely. No data loss, no timeout.
- Throughput with data_ready tied high: SETUP_CYCLES+ACCESS_CYCLES+1 clocks per byte.
- DONE:
  - ce_n=1, oe_n=1, done=1.
  - start=1 -> clears done, sets busy, rom_address <= 0, goes to SETUP (re-dump).
- start while busy is ignored.
- abort=1 in any state at an edge:
  - go to IDLE; data_valid <= 0; ce_n/oe_n <= 1; busy <= 0; done <= 0.
  - rom_address keeps its value so the display shows where the dump stopped.
- abort and start in the same cycle: abort wins.
- abort in the same cycle as a handshake: abort wins. Treat the byte as not delivered; downstream must drop it.
- Address arithmetic is unsigned ADDRESS_WIDTH bits. The increment never overflows, because the last address exits to DONE.
- Wait counter width is $clog2(max(SETUP_CYCLES,ACCESS_CYCLES))+1. It clears on every state entry.

Decomposition:
- Shared package rom_reader_pkg:
  - state encoding constants (IDLE=0, SETUP=1, ACCESS=2, HANDOFF=3, DONE=4, 3 bits);
  - default ADDRESS_WIDTH/DATA_WIDTH shared with address_display and the transmitter.
- One sub-module, rom_wait_timer:
  - loadable down-counter with load value and load strobe inputs, pulsing expired for one cycle.
  - Used for both SETUP and ACCESS delays.
- FSM, address register and output register stay in rom_read_sequencer.

Test Plan:
1. Reset mid-ACCESS at address 17 -> next edge: ce_n=1, oe_n=1, data_valid=0, busy=0, rom_address=0, state IDLE.
2. SETUP=2, ACCESS=4, data_ready=1, ROM model returns (addr XOR 0x5A) & 0xFF:
   - pulse start -> 512 transfers, each data_out equal to the model value;
   - 7 clocks between successive transfers;
   - done rises 3584 clocks after the first SETUP cycle; rom_address=511 in DONE.
3. Check each byte's timing:
   - ce_n falls at least 2 clocks before oe_n;
   - oe_n stays low exactly 4 clocks;
   - rom_address never changes while ce_n=0.
4. Hold data_ready=0 for 20 clocks at address 3 -> data_valid stays 1 and data_out stays constant. Raise ready -> exactly one transfer, then address 4.
5. Assert abort during HANDOFF at address 100 with data_ready=1 in the same cycle -> IDLE, data_valid=0, rom_address=100, done=0. Then start -> restart from address 0.
6. start pulsed while busy at address 10 -> ignored, no address reset. start in DONE -> done clears, dump restarts from 0.

Source files
------------

// File: rtl/rom_reader_pkg.sv
// Shared definitions for the ROM dump path (sequencer, address display, transmitter).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: state encoding, default bus widths, small helper functions.
package rom_reader_pkg;

  localparam int DEF_ADDRESS_WIDTH = 9;
  localparam int DEF_DATA_WIDTH    = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_ACCESS  = 3'd2,
    ST_HANDOFF = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rom_read_sequencer_if.sv
// ROM pin bus plus the captured-byte valid/ready stream, bundled for the sequencer.
// Latency: n/a (wires only).
// Backpressure: data_ready from the consumer stalls the byte stream.
// Modports: master = sequencer (drives ROM pins and stream), slave = ROM/consumer side.
interface rom_read_sequencer_if
  import rom_reader_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH
) ();

  logic [ADDRESS_WIDTH-1:0] rom_address;
  logic                     rom_ce_n;
  logic                     rom_oe_n;
  logic [DATA_WIDTH-1:0]    rom_data;
  logic [DATA_WIDTH-1:0]    data_out;
  logic                     data_valid;
  logic                     data_ready;

  modport master (
    output rom_address, rom_ce_n, rom_oe_n, data_out, data_valid,
    input  rom_data, data_ready
  );

  modport slave (
    input  rom_address, rom_ce_n, rom_oe_n, data_out, data_valid,
    output rom_data, data_ready
  );

endinterface

// File: rtl/rom_wait_timer.sv
// Loadable down-counter that pulses expired_o once when a loaded count runs out.
// Latency: expired_o is high during the (load_val_i+1)-th cycle after the load edge.
// Backpressure: none; a new load restarts the count immediately.
// Ports: clk, reset (sync, active-low), load_i strobe, load_val_i count, expired_o pulse.
module rom_wait_timer #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             expired_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             armed_q, armed_d;

  // armed keeps the zero-detect from firing repeatedly while idle at zero
  assign expired_o = armed_q && (cnt_q == '0);

  always_comb begin
    cnt_d   = cnt_q;
    armed_d = armed_q;
    if (load_i) begin
      cnt_d   = load_val_i;
      armed_d = 1'b1;
    end else if (armed_q) begin
      if (cnt_q == '0) begin
        armed_d = 1'b0;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
    end
  end

endmodule

// File: rtl/rom_read_sequencer.sv
// Walks every ROM address with ce_n/oe_n timing and streams each captured byte downstream.
// Latency: SETUP_CYCLES+ACCESS_CYCLES+1 clocks per byte with data_ready held high.
// Backpressure: holds the byte in HANDOFF indefinitely while data_ready is low; no data loss.
// Ports: clk, reset (sync, active-low), start, abort, busy, done, bus (ROM pins + byte stream).
module rom_read_sequencer
  import rom_reader_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int SETUP_CYCLES  = 2,
  parameter int ACCESS_CYCLES = 50
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  rom_read_sequencer_if.master bus
);

  localparam int CNT_W = $clog2(max_int(SETUP_CYCLES, ACCESS_CYCLES)) + 1;
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR   = '1;
  // Timer counts down to zero inclusive, so N cycles need a load of N-1.
  localparam logic [CNT_W-1:0]         SETUP_LOAD  = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0]         ACCESS_LOAD = CNT_W'(ACCESS_CYCLES - 1);

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic                     ce_n_q, ce_n_d;
  logic                     oe_n_q, oe_n_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;
  logic                     valid_q, valid_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;

  logic                     tmr_load;
  logic [CNT_W-1:0]         tmr_val;
  logic                     tmr_expired;

  rom_wait_timer #(.CNT_W(CNT_W)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .expired_o (tmr_expired)
  );

  assign bus.rom_address = addr_q;
  assign bus.rom_ce_n    = ce_n_q;
  assign bus.rom_oe_n    = oe_n_q;
  assign bus.data_out    = data_q;
  assign bus.data_valid  = valid_q;
  assign busy            = busy_q;
  assign done            = done_q;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    ce_n_d   = ce_n_q;
    oe_n_d   = oe_n_q;
    data_d   = data_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    done_d   = done_q;
    tmr_load = 1'b0;
    tmr_val  = SETUP_LOAD;

    if (abort) begin
      // Address is kept so the display shows where the dump stopped; a byte
      // in HANDOFF counts as undelivered even if data_ready is also high.
      state_d = ST_IDLE;
      valid_d = 1'b0;
      ce_n_d  = 1'b1;
      oe_n_d  = 1'b1;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d  = ST_SETUP;
            addr_d   = '0;
            ce_n_d   = 1'b0;
            oe_n_d   = 1'b1;
            busy_d   = 1'b1;
            done_d   = 1'b0;
            tmr_load = 1'b1;
            tmr_val  = SETUP_LOAD;
          end
        end
        ST_SETUP: begin
          if (tmr_expired) begin
            state_d  = ST_ACCESS;
            oe_n_d   = 1'b0;
            tmr_load = 1'b1;
            tmr_val  = ACCESS_LOAD;
          end
        end
        ST_ACCESS: begin
          if (tmr_expired) begin
            state_d = ST_HANDOFF;
            data_d  = bus.rom_data;
            valid_d = 1'b1;
            ce_n_d  = 1'b1;
            oe_n_d  = 1'b1;
          end
        end
        ST_HANDOFF: begin
          if (bus.data_ready) begin
            valid_d = 1'b0;
            if (addr_q == LAST_ADDR) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
              busy_d  = 1'b0;
            end else begin
              state_d  = ST_SETUP;
              addr_d   = addr_q + ADDRESS_WIDTH'(1);
              ce_n_d   = 1'b0;
              tmr_load = 1'b1;
              tmr_val  = SETUP_LOAD;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          ce_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_rom_read_sequencer.sv
// Directed bench for rom_read_sequencer with a ROM model returning addr XOR 0x5A.
// Timing: inputs driven and outputs sampled 1ns after posedge; monitor samples on negedge.
// Covers reset, full dump timing/data, backpressure, abort, start-while-busy, re-dump.
module tb_rom_read_sequencer;
  import rom_reader_pkg::*;

  localparam int AW = 9;
  localparam int DW = 8;

  logic clk;
  logic reset;
  logic start;
  logic abort;
  logic busy;
  logic done;

  int n_asserts = 0;
  int n_fail    = 0;

  rom_read_sequencer_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  rom_read_sequencer #(
    .ADDRESS_WIDTH(AW),
    .DATA_WIDTH   (DW),
    .SETUP_CYCLES (2),
    .ACCESS_CYCLES(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .abort(abort),
    .busy (busy),
    .done (done),
    .bus  (bus)
  );

  // ROM drives garbage unless output-enabled, so early capture is visible.
  assign bus.rom_data = bus.rom_oe_n ? 8'hFF : (bus.rom_address[7:0] ^ 8'h5A);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rom_model(input logic [AW-1:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_asserts++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- full-dump monitor (negedge sampling) ----------------
  logic           mon_en = 1'b0;
  int             cyc = 0;
  int             last_xfer;
  int             xfer_cnt;
  logic [AW-1:0]  exp_addr;
  logic           prev_ce, prev_oe;
  logic [AW-1:0]  prev_addr;
  int             pre_cnt, oe_cnt;
  logic           addr_bad;

  always @(negedge clk) begin
    cyc++;
    if (!mon_en) begin
      last_xfer = -1;
      xfer_cnt  = 0;
      exp_addr  = '0;
      prev_ce   = 1'b1;
      prev_oe   = 1'b1;
      prev_addr = '0;
      pre_cnt   = 0;
      oe_cnt    = 0;
      addr_bad  = 1'b0;
    end else begin
      // transfer happens at the coming edge
      if (bus.data_valid && bus.data_ready && !abort && reset) begin
        chk("xfer_data", 32'(bus.data_out), 32'(rom_model(bus.rom_address)));
        chk("xfer_addr", 32'(bus.rom_address), 32'(exp_addr));
        if (last_xfer >= 0) chk("xfer_spacing", 32'(cyc - last_xfer), 32'd7);
        last_xfer = cyc;
        xfer_cnt++;
        exp_addr = exp_addr + 1'b1;
      end
      if (!bus.rom_ce_n && bus.rom_oe_n) pre_cnt++;
      if (bus.rom_ce_n) pre_cnt = 0;
      if (!bus.rom_oe_n && prev_oe) chk("ce_before_oe", 32'(pre_cnt >= 2), 32'd1);
      if (!bus.rom_oe_n) oe_cnt++;
      else if (!prev_oe) begin
        chk("oe_low_len", 32'(oe_cnt), 32'd4);
        oe_cnt = 0;
      end
      if (!bus.rom_ce_n && !prev_ce && (bus.rom_address != prev_addr)) addr_bad = 1'b1;
      if (bus.rom_ce_n && !prev_ce) begin
        chk("addr_stable_ce", 32'(addr_bad), 32'd0);
        addr_bad = 1'b0;
      end
      prev_ce   = bus.rom_ce_n;
      prev_oe   = bus.rom_oe_n;
      prev_addr = bus.rom_address;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int            n;
    logic [DW-1:0] held;
    logic          stall_bad;

    reset = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    bus.data_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b1;
    tick();

    chk("rst_ce_n",  32'(bus.rom_ce_n), 32'd1);
    chk("rst_oe_n",  32'(bus.rom_oe_n), 32'd1);
    chk("rst_valid", 32'(bus.data_valid), 32'd0);
    chk("rst_data",  32'(bus.data_out), 32'd0);
    chk("rst_addr",  32'(bus.rom_address), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_done",  32'(done), 32'd0);

    // 1: reset in the middle of ACCESS at address 17
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (!(bus.rom_address == 17 && !bus.rom_oe_n) && n < 1000) begin tick(); n++; end
    chk("t1_reach_17", 32'(bus.rom_address == 17 && !bus.rom_oe_n), 32'd1);
    reset = 1'b0; tick();
    chk("t1_ce_n",  32'(bus.rom_ce_n), 32'd1);
    chk("t1_oe_n",  32'(bus.rom_oe_n), 32'd1);
    chk("t1_valid", 32'(bus.data_valid), 32'd0);
    chk("t1_busy",  32'(busy), 32'd0);
    chk("t1_addr",  32'(bus.rom_address), 32'd0);
    chk("t1_state", 32'(dut.state_q), 32'(ST_IDLE));
    reset = 1'b1; tick();

    // 2/3: full dump, data and pin timing checked by the monitor
    mon_en = 1'b1;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    chk("t2_busy_first", 32'(busy), 32'd1);
    n = 0;
    while (!done && n < 4000) begin tick(); n++; end
    chk("t2_done_cycles", 32'(n), 32'd3584);
    chk("t2_done_addr",   32'(bus.rom_address), 32'd511);
    chk("t2_done_busy",   32'(busy), 32'd0);
    tick();
    chk("t2_xfer_count",  32'(xfer_cnt), 32'd512);
    chk("t2_done_held",   32'(done), 32'd1);
    mon_en = 1'b0;

    // 6b: start in DONE re-dumps from 0
    start = 1'b1; tick(); start = 1'b0;
    chk("t6_done_clr", 32'(done), 32'd0);
    chk("t6_busy",     32'(busy), 32'd1);
    chk("t6_addr0",    32'(bus.rom_address), 32'd0);
    chk("t6_ce_low",   32'(bus.rom_ce_n), 32'd0);

    // 4: backpressure at address 3
    n = 0;
    while (bus.rom_address != 3 && n < 100) begin tick(); n++; end
    chk("t4_reach_3", 32'(bus.rom_address), 32'd3);
    bus.data_ready = 1'b0;
    n = 0;
    while (!bus.data_valid && n < 20) begin tick(); n++; end
    chk("t4_valid", 32'(bus.data_valid), 32'd1);
    held = bus.data_out;
    stall_bad = 1'b0;
    repeat (20) begin
      tick();
      if (!bus.data_valid || bus.data_out != held || bus.rom_address != 3) stall_bad = 1'b1;
    end
    chk("t4_stall_stable", 32'(stall_bad), 32'd0);
    chk("t4_data",         32'(held), 32'h59);
    chk("t4_state",        32'(dut.state_q), 32'(ST_HANDOFF));
    bus.data_ready = 1'b1;
    tick();
    chk("t4_valid_drop", 32'(bus.data_valid), 32'd0);
    chk("t4_addr4",      32'(bus.rom_address), 32'd4);
    tick();
    chk("t4_one_xfer",   32'(bus.rom_address), 32'd4);

    // 6a: start while busy at address 10 is ignored
    n = 0;
    while (bus.rom_address != 10 && n < 200) begin tick(); n++; end
    chk("t6_reach_10", 32'(bus.rom_address), 32'd10);
    start = 1'b1; tick(); start = 1'b0;
    chk("t6_ign_addr", 32'(bus.rom_address), 32'd10);
    chk("t6_ign_busy", 32'(busy), 32'd1);
    repeat (3) tick();
    chk("t6_ign_addr_later", 32'(bus.rom_address), 32'd10);

    // 5: abort during HANDOFF at address 100 with ready high
    n = 0;
    while (!(bus.rom_address == 100 && bus.data_valid) && n < 1000) begin tick(); n++; end
    chk("t5_reach_100", 32'(bus.rom_address == 100 && bus.data_valid), 32'd1);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("t5_state", 32'(dut.state_q), 32'(ST_IDLE));
    chk("t5_valid", 32'(bus.data_valid), 32'd0);
    chk("t5_addr",  32'(bus.rom_address), 32'd100);
    chk("t5_done",  32'(done), 32'd0);
    chk("t5_busy",  32'(busy), 32'd0);
    chk("t5_ce_n",  32'(bus.rom_ce_n), 32'd1);
    start = 1'b1; tick(); start = 1'b0;
    chk("t5_restart_addr", 32'(bus.rom_address), 32'd0);
    chk("t5_restart_busy", 32'(busy), 32'd1);
    n = 0;
    while (!bus.data_valid && n < 20) begin tick(); n++; end
    chk("t5_first_data", 32'(bus.data_out), 32'h5A);
    chk("t5_first_addr", 32'(bus.rom_address), 32'd0);

    // abort and start together: abort wins
    abort = 1'b1; start = 1'b1; tick(); abort = 1'b0; start = 1'b0;
    chk("ab_st_state", 32'(dut.state_q), 32'(ST_IDLE));
    chk("ab_st_busy",  32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
